snes_pad: RTL and testbench

Controller-side responder for the SNES serial pad protocol: it emulates a standard 12-button SNES controller. It samples a parallel button vector when the host raises `data_latch`, then shifts the button states out serially on `data_in`-compatible line `data_out`, one bit per rising edge of `data_pulse`. Both host strobes are asynchronous to `clk` and are synchronized internally. It sits opposite the host-side pad reader, so the design can loop a synthetic pad back into the reader or drive a real console port.

---
 rtl/snes_pad.sv | 92 +++++++++
 tb/tb_snes_pad.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/snes_pad.sv
// SNES controller emulator: snapshots a 12-button vector on the host latch
// strobe and shifts it out active-low, one bit per host data_pulse rising edge.
module snes_pad #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_latch,
    input  logic        data_pulse,
    input  logic [11:0] buttons,
    output logic        data_out,
    output logic        frame_done
);

    logic [SYNC_STAGES-1:0] lat_sync_reg;
    logic [SYNC_STAGES-1:0] pul_sync_reg;
    logic                   pul_prev_reg;

    logic [15:0] sreg_reg, sreg_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        frame_done_reg, frame_done_next;

    logic lat_s;
    logic pul_s;
    logic pul_rise;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        lat_sync_reg[gi] <= 1'b0;
                        pul_sync_reg[gi] <= 1'b1;
                    end else begin
                        lat_sync_reg[gi] <= data_latch;
                        pul_sync_reg[gi] <= data_pulse;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        lat_sync_reg[gi] <= 1'b0;
                        pul_sync_reg[gi] <= 1'b1;
                    end else begin
                        lat_sync_reg[gi] <= lat_sync_reg[gi-1];
                        pul_sync_reg[gi] <= pul_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign lat_s    = lat_sync_reg[SYNC_STAGES-1];
    assign pul_s    = pul_sync_reg[SYNC_STAGES-1];
    assign pul_rise = pul_s & ~pul_prev_reg;

    // Load wins over shift; the counter saturates so frame_done fires once.
    always_comb begin
        sreg_next       = sreg_reg;
        cnt_next        = cnt_reg;
        frame_done_next = 1'b0;
        if (lat_s) begin
            sreg_next = {4'b1111, ~buttons};
            cnt_next  = 5'd0;
        end else if (pul_rise) begin
            sreg_next = {1'b0, sreg_reg[15:1]};
            if (cnt_reg < 5'd16) begin
                cnt_next = cnt_reg + 5'd1;
            end
            frame_done_next = (cnt_reg == 5'd15);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pul_prev_reg   <= 1'b1;
            sreg_reg       <= 16'hFFFF;
            cnt_reg        <= 5'd0;
            frame_done_reg <= 1'b0;
        end else begin
            pul_prev_reg   <= pul_s;
            sreg_reg       <= sreg_next;
            cnt_reg        <= cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign data_out   = sreg_reg[0];
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_snes_pad.sv
// Randomized scoreboard bench for snes_pad: a host-side model predicts every
// serial bit and the frame_done count from the latched button snapshot.
module tb_snes_pad;

    logic        clk;
    logic        rst;
    logic        data_latch;
    logic        data_pulse;
    logic [11:0] buttons;
    logic        data_out;
    logic        frame_done;

    snes_pad #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_latch (data_latch),
        .data_pulse (data_pulse),
        .buttons    (buttons),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        exp_q[$];
    string       name_q[$];
    event        chk_ev;

    // reference model state
    logic [15:0] snap;
    int          shifts;
    int          fd_exp = 0;
    int          fd_seen = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endfunction

    // monitor: pops the next expected bit whenever a sample is requested
    always begin
        @(chk_ev);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=%0b required=none", data_out);
        end else begin
            chk(name_q.pop_front(), {31'd0, data_out}, {31'd0, exp_q.pop_front()});
        end
    end

    // frame_done monitor: count high cycles, and the line must already be 0
    always @(negedge clk) begin
        if (!rst && frame_done === 1'b1) begin
            fd_seen++;
            chk("frame_done_line_low", {31'd0, data_out}, 32'd0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic sample(input logic exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        -> chk_ev;
        #1;
    endtask

    task automatic raw_pulse();
        data_pulse = 1'b0;
        wait_cyc($urandom_range(3, 6));
        data_pulse = 1'b1;
        wait_cyc($urandom_range(4, 6));
    endtask

    // latch b; optionally fire pulses that must be ignored while latched
    task automatic do_latch(input logic [11:0] b, input int inside_pulses);
        buttons    = b;
        data_latch = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < inside_pulses; i++) raw_pulse();
        wait_cyc(6);
        data_latch = 1'b0;
        wait_cyc(4);
        snap   = {4'hF, ~b};
        shifts = 0;
        sample(snap[0], $sformatf("bit0 btn=%03h", b));
    endtask

    task automatic do_pulse();
        logic e;
        raw_pulse();
        shifts++;
        e = (shifts < 16) ? snap[shifts] : 1'b0;
        if (shifts == 16) fd_exp++;
        sample(e, $sformatf("shift%0d", shifts));
    endtask

    task automatic check_fd(input string name);
        chk(name, fd_seen, fd_exp);
    endtask

    initial begin
        rst        = 1'b1;
        data_latch = 1'b0;
        data_pulse = 1'b1;
        buttons    = 12'h000;
        wait_cyc(3);
        chk("reset_data_out", {31'd0, data_out}, 32'd1);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        wait_cyc(5);
        chk("post_reset_idle", {31'd0, data_out}, 32'd1);

        // single B press, full frame
        do_latch(12'h001, 0);
        for (int i = 0; i < 16; i++) do_pulse();
        check_fd("fd_after_001");

        // alternating pattern
        do_latch(12'hA5A, 0);
        for (int i = 0; i < 16; i++) do_pulse();
        check_fd("fd_after_A5A");

        // snapshot held when buttons change after the latch
        do_latch(12'h000, 0);
        buttons = 12'hFFF;
        for (int i = 0; i < 12; i++) do_pulse();
        check_fd("fd_after_hold");

        // partial frame, then re-latch with pulses during the latch
        do_latch(12'h3C6, 0);
        for (int i = 0; i < 5; i++) do_pulse();
        do_latch(12'h3C6, 3);
        for (int i = 0; i < 16; i++) do_pulse();
        check_fd("fd_after_relatch");

        // overrun past the end of frame
        do_latch(12'h000, 0);
        for (int i = 0; i < 20; i++) do_pulse();
        check_fd("fd_after_overrun");

        // asynchronous reset mid-frame
        do_latch(12'hFFF, 0);
        do_pulse();
        do_pulse();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_out", {31'd0, data_out}, 32'd1);
        chk("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(6);
        chk("rst_release_no_shift", {31'd0, data_out}, 32'd1);
        check_fd("fd_after_reset");

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            int n;
            do_latch(12'($urandom), 0);
            n = $urandom_range(16, 20);
            for (int i = 0; i < n; i++) do_pulse();
            check_fd($sformatf("fd_random%0d", f));
        end

        wait_cyc(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
